// File: rtl/noc_vc_fifo_pkg.sv
// Shared types for the NoC virtual-channel input buffer.
// Flit width default and VC/flit typedefs used by the router port.
package noc_pkg;
    localparam int FLIT_W     = 40;
    localparam int NUM_VC_DEF = 2;

    typedef logic [$clog2(NUM_VC_DEF)-1:0] vc_id_t;
    typedef logic [FLIT_W-1:0]             flit_t;
endpackage

// File: rtl/noc_vc_fifo_ctrl.sv
// Per-VC pointer, occupancy and flag control for noc_vc_fifo.
// Flags and count are registered from next-state pointers.
module noc_vc_fifo_ctrl
    import noc_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             fifo_clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             wr_ok,
    output logic             rd_ok,
    output logic [PTR_W-1:0] waddr,
    output logic [PTR_W-1:0] raddr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty_n
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0] w_ptr;
    logic [PTR_W:0] r_ptr;
    logic [PTR_W:0] w_nxt;
    logic [PTR_W:0] r_nxt;
    logic [PTR_W:0] cnt_nxt;

    assign wr_ok = wr_req && !full;
    assign rd_ok = rd_req && empty_n;
    assign waddr = w_ptr[PTR_W-1:0];
    assign raddr = r_ptr[PTR_W-1:0];

    always_comb begin
        w_nxt   = w_ptr + {{PTR_W{1'b0}}, wr_ok};
        r_nxt   = r_ptr + {{PTR_W{1'b0}}, rd_ok};
        cnt_nxt = w_nxt - r_nxt;
    end

    always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty_n <= 1'b0;
        end else begin
            w_ptr   <= w_nxt;
            r_ptr   <= r_nxt;
            count   <= cnt_nxt;
            full    <= (cnt_nxt == FULL_CNT);
            empty_n <= (cnt_nxt != '0);
        end
    end
endmodule

// File: rtl/noc_vc_fifo.sv
// Multi-VC input buffer: shared storage, per-VC control, registered read.
// NOC_FIFO_CREDIT_EN adds a per-VC credit pulse aligned with rvalid.
module noc_vc_fifo
    import noc_pkg::*;
#(
    parameter  int DATASIZE = FLIT_W,
    parameter  int DEPTH    = 8,
    parameter  int NUM_VC   = 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int VC_W     = $clog2(NUM_VC)
) (
    input  logic                          fifo_clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [VC_W-1:0]               wr_vc,
    input  logic [DATASIZE-1:0]           wdata,
    input  logic                          rd_en,
    input  logic [VC_W-1:0]               rd_vc,
    output logic [DATASIZE-1:0]           rdata,
    output logic                          rvalid,
    output logic [NUM_VC-1:0]             full,
    output logic [NUM_VC-1:0]             empty_n,
    output logic [NUM_VC*(PTR_W+1)-1:0]   count
`ifdef NOC_FIFO_CREDIT_EN
    ,
    output logic [NUM_VC-1:0]             credit
`endif
);
    logic [NUM_VC-1:0] wr_ok;
    logic [NUM_VC-1:0] rd_ok;
    logic [PTR_W-1:0]  waddr [NUM_VC];
    logic [PTR_W-1:0]  raddr [NUM_VC];
    logic [DATASIZE-1:0] mem [NUM_VC*DEPTH];
    logic wr_hit;
    logic rd_hit;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        noc_vc_fifo_ctrl #(
            .DEPTH(DEPTH)
        ) u_ctrl (
            .fifo_clk(fifo_clk),
            .rst_n   (rst_n),
            .wr_req  (wr_en && (wr_vc == VC_W'(v))),
            .rd_req  (rd_en && (rd_vc == VC_W'(v))),
            .wr_ok   (wr_ok[v]),
            .rd_ok   (rd_ok[v]),
            .waddr   (waddr[v]),
            .raddr   (raddr[v]),
            .count   (count[v*(PTR_W+1) +: PTR_W+1]),
            .full    (full[v]),
            .empty_n (empty_n[v])
        );
    end

    assign wr_hit = |wr_ok;
    assign rd_hit = |rd_ok;

    // Storage is not reset; only written entries are ever read.
    always_ff @(posedge fifo_clk) begin
        if (wr_hit)
            mem[{wr_vc, waddr[wr_vc]}] <= wdata;
    end

    always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_hit;
            if (rd_hit)
                rdata <= mem[{rd_vc, raddr[rd_vc]}];
        end
    end

`ifdef NOC_FIFO_CREDIT_EN
    always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n)
            credit <= '0;
        else
            credit <= rd_hit ? (NUM_VC'(1) << rd_vc) : '0;
    end
`endif
endmodule

// File: tb/tb_noc_vc_fifo.sv
// Randomised and directed bench for noc_vc_fifo against a queue-based model.
// Credit checks are active when NOC_FIFO_CREDIT_EN is defined.
module tb_noc_vc_fifo;
    localparam int DW    = 40;
    localparam int DEPTH = 8;
    localparam int NVC   = 2;
    localparam int CW    = 4;

    logic          fifo_clk = 1'b0;
    logic          rst_n    = 1'b0;
    logic          wr_en    = 1'b0;
    logic          wr_vc    = 1'b0;
    logic [DW-1:0] wdata    = '0;
    logic          rd_en    = 1'b0;
    logic          rd_vc    = 1'b0;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic [NVC-1:0] full;
    logic [NVC-1:0] empty_n;
    logic [NVC*CW-1:0] count;
`ifdef NOC_FIFO_CREDIT_EN
    logic [NVC-1:0] credit;
`endif

    noc_vc_fifo #(
        .DATASIZE(DW),
        .DEPTH   (DEPTH),
        .NUM_VC  (NVC)
    ) dut (
        .fifo_clk(fifo_clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_vc   (wr_vc),
        .wdata   (wdata),
        .rd_en   (rd_en),
        .rd_vc   (rd_vc),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .full    (full),
        .empty_n (empty_n),
        .count   (count)
`ifdef NOC_FIFO_CREDIT_EN
        ,
        .credit  (credit)
`endif
    );

    always #5 fifo_clk = ~fifo_clk;

    int errors = 0;
    int checks = 0;
    int credits = 0;

    logic [DW-1:0]  q [NVC][$];
    logic           m_rvalid;
    logic [DW-1:0]  m_rdata;
    logic [NVC-1:0] m_credit;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] cnt(int v);
        return count[v*CW +: CW];
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NVC; v++) q[v].delete();
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_credit = '0;
    endtask

    task automatic model_edge();
        bit wok;
        bit rok;
        wok = wr_en && (q[wr_vc].size() < DEPTH);
        rok = rd_en && (q[rd_vc].size() != 0);
        m_credit = '0;
        if (rok) begin
            m_rdata  = q[rd_vc].pop_front();
            m_rvalid = 1'b1;
            m_credit[rd_vc] = 1'b1;
        end else begin
            m_rvalid = 1'b0;
        end
        if (wok) q[wr_vc].push_back(wdata);
    endtask

    task automatic compare_all();
        for (int v = 0; v < NVC; v++) begin
            chk($sformatf("count%0d", v), 64'(cnt(v)), 64'(q[v].size()));
            chk($sformatf("full%0d", v), 64'(full[v]),
                64'(q[v].size() == DEPTH));
            chk($sformatf("empty_n%0d", v), 64'(empty_n[v]),
                64'(q[v].size() != 0));
        end
        chk("rvalid", 64'(rvalid), 64'(m_rvalid));
        chk("rdata", 64'(rdata), 64'(m_rdata));
`ifdef NOC_FIFO_CREDIT_EN
        chk("credit", 64'(credit), 64'(m_credit));
        if (credit[1]) credits++;
`endif
    endtask

    task automatic step(bit we, bit wv, logic [DW-1:0] wd, bit re, bit rv);
        wr_en = we;
        wr_vc = wv;
        wdata = wd;
        rd_en = re;
        rd_vc = rv;
        @(posedge fifo_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("mrst_rvalid", 64'(rvalid), 64'd0);
        chk("mrst_count", 64'(count), 64'd0);
        @(negedge fifo_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] oldest;
        model_reset();
        #12;
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_empty_n", 64'(empty_n), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        compare_all();
        @(negedge fifo_clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) step(1, 0, DW'(8'hA0 + i), 0, 0);
        chk("t2_count0", 64'(cnt(0)), 64'd8);
        chk("t2_full0", 64'(full[0]), 64'd1);
        step(1, 0, DW'(8'hFF), 0, 0);
        chk("t2_drop", 64'(cnt(0)), 64'd8);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, '0, 1, 0);
            chk("t2_rdata", 64'(rdata), 64'(8'hA0 + i));
            chk("t2_rvalid", 64'(rvalid), 64'd1);
        end
        chk("t2_empty0", 64'(empty_n[0]), 64'd0);

        for (int i = 0; i < 4; i++) step(1, 0, DW'(8'hB0 + i), 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, DW'(8'hC0 + i), 1, 0);
        chk("t3_count0", 64'(cnt(0)), 64'd0);
        chk("t3_count1", 64'(cnt(1)), 64'd4);

        for (int i = 0; i < 8; i++) step(1, 0, DW'(8'hD0 + i), 0, 0);
        chk("t4_full0", 64'(full[0]), 64'd1);
        oldest = q[0][0];
        step(1, 0, DW'(8'hEE), 1, 0);
        chk("t4_rdata", 64'(rdata), 64'(8'hD0));
        chk("t4_model", 64'(oldest), 64'(8'hD0));
        chk("t4_count0", 64'(cnt(0)), 64'd7);

        while (q[1].size() != 0) step(0, 0, '0, 1, 1);
        step(1, 1, DW'(8'h55), 1, 1);
        chk("t5_rvalid", 64'(rvalid), 64'd0);
        chk("t5_count1", 64'(cnt(1)), 64'd1);
        chk("t5_empty1", 64'(empty_n[1]), 64'd1);

        step(1, 1, DW'(8'h56), 0, 0);
        credits = 0;
        for (int i = 0; i < 20; i++) step(1, 1, DW'(12'h100 + i), 1, 1);
        chk("t6_count1", 64'(cnt(1)), 64'd2);
`ifdef NOC_FIFO_CREDIT_EN
        chk("t6_credits", 64'(credits), 64'd20);
`endif
        for (int i = 0; i < 3; i++) step(1, 1, DW'(12'h200 + i), 1, 1);
        mid_reset();

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 100) < 60, $urandom % 2,
                 {$urandom, 8'($urandom)},
                 ($urandom % 100) < 45, $urandom % 2);
            if (i == 300) mid_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
